// File: rtl/inv_key_schedule.sv
// inv_key_schedule -- sequential AES-128 inverse key schedule.
// Loads the round-10 key and walks the schedule backwards. It emits one round
// key per accepted valid/ready transfer, from round ROUNDS down to round 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load request, sampled only in IDLE
//   last_key     round-10 key (word 0 in [127:96], word 3 in [31:0])
//   busy         high while a sequence is running
//   key_out      current round key
//   key_round    round index of key_out
//   key_valid    key_out/key_round valid
//   key_ready    consumer accepts on key_valid && key_ready
//   done         one-cycle pulse after the round-0 key is accepted

// subbytes -- AES S-box applied to every byte of a W-bit word.
// Ports: din (W bits) in, dout (W bits) out; combinational.
module subbytes #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar b = 0; b < W / 8; b++) begin : g_byte
        assign dout[b*8 +: 8] = SBOX[din[b*8 +: 8]];
    end
endmodule

module inv_key_schedule #(
    parameter int unsigned N      = 128,
    parameter int unsigned ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] last_key,
    output logic         busy,
    output logic [N-1:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sub_w;
    logic [7:0]  rcon;
    logic [N-1:0] prev_key;

    assign w0 = key_out[127:96];
    assign w1 = key_out[95:64];
    assign w2 = key_out[63:32];
    assign w3 = key_out[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // SubWord(RotWord(p3)); p3 is the previous key's last word, which is
    // exactly the word the forward expansion fed into SubWord.
    subbytes #(.W(32)) u_subword (
        .din  ({p3[23:0], p3[31:24]}),
        .dout (sub_w)
    );

    // Rcon is indexed by the current (later) round, not by the one produced.
    always_comb begin
        rcon = 8'h00;
        case (key_round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign p0       = w0 ^ sub_w ^ {rcon, 24'h000000};
    assign prev_key = {p0, p1, p2, p3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_out   <= '0;
            key_round <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_out   <= last_key;
                        key_round <= 4'(ROUNDS);
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (key_valid && key_ready) begin
                        if (key_round == 4'd0) begin
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            key_out   <= prev_key;
                            key_round <= key_round - 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule -- scoreboard bench for inv_key_schedule.
// Expected keys come from a forward AES-128 expansion model whose S-box is
// derived from GF(2^8) inversion plus the affine map.
module tb_inv_key_schedule;
    localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_LAST  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] JUNK    = 128'h0123456789abcdeffedcba9876543210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] last_key = '0;
    logic         busy;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         key_ready = 1'b1;
    logic         done;

    inv_key_schedule #(.N(128), .ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .last_key  (last_key),
        .busy      (busy),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    // Forward expansion of cipher key, returning round key n.
    function automatic logic [127:0] fwd_round(input logic [127:0] cipher, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        w[0] = cipher[127:96]; w[1] = cipher[95:64];
        w[2] = cipher[63:32];  w[3] = cipher[31:0];
        for (int i = 4; i < 4 * n + 4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         q [$];
    logic [127:0] drv_cipher = '0;
    logic [127:0] m_cipher = '0;
    bit           m_run = 1'b0;
    bit           exp_done = 1'b0;

    always @(negedge clk) begin
        bit was_run;
        bit acc;
        if (!rst_n) begin
            q.delete();
            m_run    = 1'b0;
            exp_done = 1'b0;
        end else begin
            check_eq("done", 128'(done), 128'(exp_done));
            check_eq("busy", 128'(busy), 128'(m_run));
            check_eq("valid", 128'(key_valid), 128'(m_run));
            was_run = m_run;
            acc = 1'b0;
            if (m_run && q.size() > 0) begin
                check_eq("key", key_out, q[0].key);
                check_eq("round", 128'(key_round), 128'(q[0].rnd));
                if (key_valid && key_ready) begin
                    if (m_cipher == A1_KEY) begin
                        case (q[0].rnd)
                            4'd10: check_eq("fips_r10", key_out, A1_LAST);
                            4'd9:  check_eq("fips_r9", key_out, 128'hac7766f319fadc2128d12941575c006e);
                            4'd1:  check_eq("fips_r1", key_out, 128'ha0fafe1788542cb123a339392a6c7605);
                            4'd0:  check_eq("fips_r0", key_out, A1_KEY);
                            default: ;
                        endcase
                    end
                    void'(q.pop_front());
                    acc = 1'b1;
                end
            end
            exp_done = 1'b0;
            if (was_run && acc && q.size() == 0) begin
                m_run    = 1'b0;
                exp_done = 1'b1;
            end else if (!was_run && start) begin
                m_cipher = drv_cipher;
                for (int r = 10; r >= 0; r--) q.push_back('{4'(r), fwd_round(drv_cipher, r)});
                m_run = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic pick_ready(input bit rnd);
        return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Runs one sequence; inj pulses start with a junk key at rounds 7 and 0.
    task automatic run_seq(input logic [127:0] cipher, input logic [127:0] lk,
                           input bit rnd, input bit inj, input bit chk_lat);
        int cnt = 0;
        bit seen = 1'b0;
        @(posedge clk); #1;
        drv_cipher = cipher;
        last_key   = lk;
        start      = 1'b1;
        key_ready  = pick_ready(rnd);
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            cnt++;
            start = inj && key_valid && (key_round == 4'd7 || key_round == 4'd0);
            if (start) last_key = JUNK;
            key_ready = pick_ready(rnd);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        key_ready = 1'b1;
        if (!seen) check_eq("timeout_done", 128'(0), 128'(1));
        if (chk_lat) check_eq("done_latency", 128'(cnt), 128'(12));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [127:0] ck;
        bit seen;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

        // Reset state
        #12;
        check_eq("rst_valid", 128'(key_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_key", key_out, 128'(0));
        check_eq("rst_round", 128'(key_round), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Idle hold: monitor checks valid/busy/done each cycle
        repeat (20) @(posedge clk);

        // FIPS-197 A.1, ready high
        run_seq(A1_KEY, A1_LAST, 1'b0, 1'b0, 1'b1);
        // Backpressure
        run_seq(A1_KEY, A1_LAST, 1'b1, 1'b0, 1'b0);
        // Start during RUN (round 7 and final accept)
        run_seq(A1_KEY, A1_LAST, 1'b0, 1'b1, 1'b1);

        // Mid-sequence asynchronous reset at round 5
        @(posedge clk); #1;
        drv_cipher = A1_KEY; last_key = A1_LAST; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (key_valid && key_round == 4'd5) seen = 1'b1;
        end
        if (!seen) check_eq("timeout_r5", 128'(0), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 128'(key_valid), 128'(0));
        check_eq("mid_rst_busy", 128'(busy), 128'(0));
        check_eq("mid_rst_key", key_out, 128'(0));
        check_eq("mid_rst_round", 128'(key_round), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_seq(A1_KEY, A1_LAST, 1'b0, 1'b0, 1'b1);

        // Back-to-back with start held high: A.1 then all-zero cipher key
        @(posedge clk); #1;
        drv_cipher = A1_KEY; last_key = A1_LAST; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        if (!seen) check_eq("timeout_b2b1", 128'(0), 128'(1));
        drv_cipher = '0; last_key = Z_LAST;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("b2b_gap_busy", 128'(busy), 128'(1));
        check_eq("b2b_gap_round", 128'(key_round), 128'(10));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        if (!seen) check_eq("timeout_b2b2", 128'(0), 128'(1));
        check_eq("zero_final", key_out, 128'(0));
        repeat (2) @(posedge clk);

        // Random cipher keys under random backpressure
        for (int k = 0; k < 3; k++) begin
            ck = {$urandom, $urandom, $urandom, $urandom};
            run_seq(ck, fwd_round(ck, 10), 1'b1, 1'b0, 1'b0);
        end

        check_eq("sb_empty", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
